// File: rtl/sinusoid_analyzer_pkg.sv
// Shared encodings for the sine-stream analyzer: crossing FSM states,
// waveform class codes and the reference levels used by classification.
package sinusoid_analyzer_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam logic [1:0] CLASS_UNKNOWN = 2'd0;
  localparam logic [1:0] CLASS_PLAIN   = 2'd1;
  localparam logic [1:0] CLASS_HALF    = 2'd2;
  localparam logic [1:0] CLASS_FULL    = 2'd3;

  localparam logic [7:0] MIDSCALE   = 8'd128;
  localparam logic [7:0] HALF_FLOOR = 8'd127;

  // A half-rectified stream floors exactly one LSB below midscale.
  function automatic logic [1:0] classify(input logic [7:0] min_val);
    if (min_val < HALF_FLOOR)       return CLASS_PLAIN;
    else if (min_val == HALF_FLOOR) return CLASS_HALF;
    else                            return CLASS_FULL;
  endfunction

endpackage

// File: rtl/wave_extrema_tracker.sv
// Window sample counter with running max/min; latches peak results and
// pulses window_done on the last sample of each window.
module wave_extrema_tracker
  import sinusoid_analyzer_pkg::*;
#(
  parameter int WINDOW_LOG2 = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [7:0] wave,
  output logic       win_last,
  output logic [7:0] cur_max,
  output logic [7:0] cur_min,
  output logic [7:0] peak_max,
  output logic [7:0] peak_min,
  output logic [7:0] amplitude,
  output logic       window_done
);

  logic [WINDOW_LOG2-1:0] wcnt;
  logic [7:0]             run_max;
  logic [7:0]             run_min;

  // Extremes including the sample on the input right now.
  always_comb begin
    cur_max  = (wave > run_max) ? wave : run_max;
    cur_min  = (wave < run_min) ? wave : run_min;
    win_last = sample_valid && (wcnt == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt        <= '0;
      run_max     <= 8'h00;
      run_min     <= 8'hFF;
      peak_max    <= 8'h00;
      peak_min    <= 8'hFF;
      amplitude   <= 8'h00;
      window_done <= 1'b0;
    end else if (clear) begin
      wcnt        <= '0;
      run_max     <= 8'h00;
      run_min     <= 8'hFF;
      peak_max    <= 8'h00;
      peak_min    <= 8'hFF;
      amplitude   <= 8'h00;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (sample_valid) begin
        wcnt <= wcnt + 1'b1;
        if (win_last) begin
          peak_max    <= cur_max;
          peak_min    <= cur_min;
          amplitude   <= cur_max - cur_min;
          window_done <= 1'b1;
          run_max     <= 8'h00;
          run_min     <= 8'hFF;
        end else begin
          run_max <= cur_max;
          run_min <= cur_min;
        end
      end
    end
  end

endmodule

// File: rtl/sinusoid_wave_analyzer.sv
// Measures a strobed offset-binary sine stream: window peaks, adaptive
// mid threshold, waveform class and period between rising crossings.
module sinusoid_wave_analyzer
  import sinusoid_analyzer_pkg::*;
#(
  parameter int WINDOW_LOG2 = 9,
  parameter int HYST        = 4,
  parameter int PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic [7:0]          wave,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                overflow,
  output logic [7:0]          peak_max,
  output logic [7:0]          peak_min,
  output logic [7:0]          amplitude,
  output logic [7:0]          mid_level,
  output logic [1:0]          wave_class,
  output logic                window_done
);

  localparam logic [8:0] HYST9 = 9'(HYST);

  state_t              state;
  state_t              state_next;
  logic                rise;
  logic                first_seen;
  logic [PERIOD_W-1:0] pcnt;
  logic [PERIOD_W-1:0] pcnt_inc;
  logic                pcnt_sat;
  logic [8:0]          hi_sum;
  logic [8:0]          lo_diff;
  logic [7:0]          thr_hi;
  logic [7:0]          thr_lo;
  logic [8:0]          mid_sum;
  logic                win_last;
  logic [7:0]          cur_max;
  logic [7:0]          cur_min;

  wave_extrema_tracker #(.WINDOW_LOG2(WINDOW_LOG2)) u_extrema (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_valid (sample_valid),
    .wave         (wave),
    .win_last     (win_last),
    .cur_max      (cur_max),
    .cur_min      (cur_min),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .amplitude    (amplitude),
    .window_done  (window_done)
  );

  // Hysteresis band around the current threshold, clamped to 0..255.
  always_comb begin
    hi_sum   = {1'b0, mid_level} + HYST9;
    lo_diff  = {1'b0, mid_level} - HYST9;
    thr_hi   = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    thr_lo   = lo_diff[8] ? 8'h00 : lo_diff[7:0];
    mid_sum  = {1'b0, cur_max} + {1'b0, cur_min} + 9'd1;
    pcnt_sat = (pcnt == '1);
    pcnt_inc = pcnt_sat ? pcnt : pcnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    rise       = 1'b0;
    if (sample_valid) begin
      case (state)
        S_INIT: state_next = (wave >= mid_level) ? S_HIGH : S_LOW;
        S_LOW: begin
          if (wave >= thr_hi) begin
            state_next = S_HIGH;
            rise       = 1'b1;
          end
        end
        S_HIGH:  if (wave < thr_lo) state_next = S_LOW;
        default: state_next = S_INIT;
      endcase
    end
  end

  // The first rising crossing only arms the period measurement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_INIT;
      pcnt         <= '0;
      first_seen   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      mid_level    <= MIDSCALE;
      wave_class   <= CLASS_UNKNOWN;
    end else if (clear) begin
      state        <= S_INIT;
      pcnt         <= '0;
      first_seen   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      mid_level    <= MIDSCALE;
      wave_class   <= CLASS_UNKNOWN;
    end else begin
      period_valid <= 1'b0;
      if (sample_valid) begin
        state <= state_next;
        if (rise) begin
          pcnt       <= '0;
          first_seen <= 1'b1;
          if (first_seen) begin
            period       <= pcnt_inc;
            period_valid <= 1'b1;
            if (pcnt_sat) overflow <= 1'b1;
          end
        end else begin
          pcnt <= pcnt_inc;
        end
        if (win_last) begin
          mid_level  <= mid_sum[8:1];
          wave_class <= classify(cur_min);
        end
      end
    end
  end

endmodule

// File: tb/tb_sinusoid_wave_analyzer.sv
// Directed bench: table of square-wave scenarios plus hand sequences for
// hysteresis, period saturation and reset/clear behaviour.
module tb_sinusoid_wave_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  wave = 8'd0;

  logic [15:0] period;
  logic        period_valid;
  logic        overflow;
  logic [7:0]  peak_max;
  logic [7:0]  peak_min;
  logic [7:0]  amplitude;
  logic [7:0]  mid_level;
  logic [1:0]  wave_class;
  logic        window_done;

  logic [7:0]  o_period;
  logic        o_period_valid;
  logic        o_overflow;
  logic [7:0]  o_peak_max;
  logic [7:0]  o_peak_min;
  logic [7:0]  o_amplitude;
  logic [7:0]  o_mid_level;
  logic [1:0]  o_wave_class;
  logic        o_window_done;

  sinusoid_wave_analyzer #(.WINDOW_LOG2(5), .HYST(4), .PERIOD_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_valid (sample_valid),
    .wave         (wave),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .amplitude    (amplitude),
    .mid_level    (mid_level),
    .wave_class   (wave_class),
    .window_done  (window_done)
  );

  sinusoid_wave_analyzer #(.WINDOW_LOG2(5), .HYST(4), .PERIOD_W(8)) u_ovf (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_valid (sample_valid),
    .wave         (wave),
    .period       (o_period),
    .period_valid (o_period_valid),
    .overflow     (o_overflow),
    .peak_max     (o_peak_max),
    .peak_min     (o_peak_min),
    .amplitude    (o_amplitude),
    .mid_level    (o_mid_level),
    .wave_class   (o_wave_class),
    .window_done  (o_window_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] first_lvl;
    logic [7:0] second_lvl;
    int         half_len;
    int         stride;
    int         num_samples;
    int         exp_pv_count;
    int         exp_period;
    logic [7:0] exp_max;
    logic [7:0] exp_min;
    logic [7:0] exp_amp;
    logic [7:0] exp_mid;
    logic [1:0] exp_class;
    int         exp_wd_count;
  } vec_t;

  vec_t        vecs[4];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          pv_count;
  int          wd_count;
  int          bad_pulse;
  logic [15:0] last_period;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reset_trackers();
    pv_count    = 0;
    wd_count    = 0;
    bad_pulse   = 0;
    last_period = 16'd0;
  endtask

  // One clock with the given inputs; outputs are sampled on the following falling edge.
  task automatic apply_stimulus(input logic [7:0] w, input logic v);
    wave         = w;
    sample_valid = v;
    @(negedge clk);
    if (period_valid) begin
      pv_count++;
      last_period = period;
    end
    if (window_done) wd_count++;
    if (!v && (period_valid || window_done)) bad_pulse++;
  endtask

  task automatic apply_clear(input logic [7:0] w, input logic v);
    clear        = 1'b1;
    wave         = w;
    sample_valid = v;
    @(negedge clk);
    clear        = 1'b0;
    sample_valid = 1'b0;
    reset_trackers();
  endtask

  task automatic apply_square(input int count, input int half);
    for (int i = 0; i < count; i++)
      apply_stimulus(((i / half) % 2 == 0) ? 8'd200 : 8'd50, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " period"},       32'(period),       32'd0);
    check_output({tag, " period_valid"}, 32'(period_valid), 32'd0);
    check_output({tag, " overflow"},     32'(overflow),     32'd0);
    check_output({tag, " peak_max"},     32'(peak_max),     32'd0);
    check_output({tag, " peak_min"},     32'(peak_min),     32'd255);
    check_output({tag, " amplitude"},    32'(amplitude),    32'd0);
    check_output({tag, " mid_level"},    32'(mid_level),    32'd128);
    check_output({tag, " wave_class"},   32'(wave_class),   32'd0);
    check_output({tag, " window_done"},  32'(window_done),  32'd0);
  endtask

  initial begin
    vecs[0] = '{"plain",         8'd200, 8'd50,  8, 1, 64, 2, 16, 8'd200, 8'd50,  8'd150, 8'd125, 2'd1, 2};
    vecs[1] = '{"plain_strided", 8'd200, 8'd50,  8, 3, 64, 2, 16, 8'd200, 8'd50,  8'd150, 8'd125, 2'd1, 2};
    vecs[2] = '{"half",          8'd127, 8'd200, 8, 1, 64, 2, 16, 8'd200, 8'd127, 8'd73,  8'd164, 2'd2, 2};
    vecs[3] = '{"full",          8'd130, 8'd250, 8, 1, 64, 1, 16, 8'd250, 8'd130, 8'd120, 8'd190, 2'd3, 2};
    reset_trackers();

    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      apply_clear(8'd0, 1'b0);
      for (int i = 0; i < vecs[v].num_samples; i++) begin
        for (int s = 1; s < vecs[v].stride; s++) apply_stimulus(8'd0, 1'b0);
        apply_stimulus(((i / vecs[v].half_len) % 2 == 0) ? vecs[v].first_lvl : vecs[v].second_lvl, 1'b1);
      end
      check_output({vecs[v].name, " pv_count"},    32'(pv_count),    32'(vecs[v].exp_pv_count));
      check_output({vecs[v].name, " period"},      32'(last_period), 32'(vecs[v].exp_period));
      check_output({vecs[v].name, " peak_max"},    32'(peak_max),    32'(vecs[v].exp_max));
      check_output({vecs[v].name, " peak_min"},    32'(peak_min),    32'(vecs[v].exp_min));
      check_output({vecs[v].name, " amplitude"},   32'(amplitude),   32'(vecs[v].exp_amp));
      check_output({vecs[v].name, " mid_level"},   32'(mid_level),   32'(vecs[v].exp_mid));
      check_output({vecs[v].name, " wave_class"},  32'(wave_class),  32'(vecs[v].exp_class));
      check_output({vecs[v].name, " wd_count"},    32'(wd_count),    32'(vecs[v].exp_wd_count));
      check_output({vecs[v].name, " invalid_pulse"}, 32'(bad_pulse), 32'd0);
    end

    // Inside the 124..132 band nothing crosses; a wider swing then yields period 8.
    apply_clear(8'd0, 1'b0);
    for (int i = 0; i < 24; i++) apply_stimulus((i % 2 == 1) ? 8'd131 : 8'd126, 1'b1);
    check_output("hyst no_period", 32'(pv_count), 32'd0);
    for (int i = 0; i < 24; i++) apply_stimulus(((i / 4) % 2 == 0) ? 8'd133 : 8'd120, 1'b1);
    check_output("hyst pv_count", 32'(pv_count), 32'd2);
    check_output("hyst period", 32'(last_period), 32'd8);
    check_output("hyst mid_level", 32'(mid_level), 32'd127);

    // Long flat top after one crossing saturates the 8-bit counter.
    apply_clear(8'd0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(8'd50, 1'b1);
    for (int i = 0; i < 301; i++) apply_stimulus(8'd200, 1'b1);
    check_output("sat overflow_before", 32'(o_overflow), 32'd0);
    check_output("sat period_before", 32'(o_period), 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(8'd50, 1'b1);
    apply_stimulus(8'd255, 1'b1);
    check_output("sat period8", 32'(o_period), 32'd255);
    check_output("sat period_valid8", 32'(o_period_valid), 32'd1);
    check_output("sat overflow8", 32'(o_overflow), 32'd1);
    check_output("sat period16", 32'(period), 32'd305);
    check_output("sat overflow16", 32'(overflow), 32'd0);
    for (int i = 0; i < 40; i++) apply_stimulus(8'd50, 1'b1);
    check_output("sat overflow_sticky", 32'(o_overflow), 32'd1);
    apply_clear(8'd0, 1'b0);
    check_output("sat overflow_cleared", 32'(o_overflow), 32'd0);

    // Asynchronous reset partway through the second window.
    apply_square(42, 8);
    check_output("rst pre_window", 32'(wd_count), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b1;
    reset_trackers();
    apply_square(31, 8);
    check_output("rst partial_window", 32'(wd_count), 32'd0);
    apply_square(1, 8);
    check_output("rst full_window", 32'(wd_count), 32'd1);
    check_output("rst peak_max", 32'(peak_max), 32'd200);
    check_output("rst peak_min", 32'(peak_min), 32'd50);

    // Clear wins over a simultaneous valid sample, which must not be counted.
    apply_square(10, 8);
    apply_clear(8'd5, 1'b1);
    check_reset_values("clear");
    apply_square(31, 8);
    check_output("clear partial_window", 32'(wd_count), 32'd0);
    apply_square(1, 8);
    check_output("clear full_window", 32'(wd_count), 32'd1);
    check_output("clear peak_min", 32'(peak_min), 32'd50);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
